instruction_fetch_unit: RTL and testbench

//  Fetch stage directly upstream of InstructionMemory. Owns the PC and drives the

---
 rtl/instruction_fetch_unit_pkg.sv | 14 +
 rtl/instruction_fetch_unit_fetch_addr_check.sv | 16 +
 rtl/instruction_fetch_unit.sv | 123 ++++++++++++
 tb/tb_instruction_fetch_unit.sv | 177 +++++++++++++++++
 4 files changed

// File: rtl/instruction_fetch_unit_pkg.sv
// Shared constants and state encoding for the fetch stage and its instruction memory.
// Vectors follow the bit-0-is-MSB ordering used on the fetch interface.
package instruction_fetch_unit_pkg;

  localparam logic [0:31] RESET_PC_DEFAULT  = 32'h0000_0000;
  localparam int          MEM_BYTES_DEFAULT = 2048;
  localparam int          PC_STEP_DEFAULT   = 4;

  typedef enum logic {
    RUN   = 1'b0,
    FAULT = 1'b1
  } fetch_state_e;

endpackage

// File: rtl/instruction_fetch_unit_fetch_addr_check.sv
// Combinational legality check for a fetch byte address.
// Legal means word aligned and inside the instruction memory.
module fetch_addr_check
  import instruction_fetch_unit_pkg::*;
#(
  parameter int MEM_BYTES = MEM_BYTES_DEFAULT
) (
  input  logic [0:31] i_addr,
  output logic        o_legal
);

  localparam logic [0:31] LAST_WORD = 32'(MEM_BYTES - 4);

  assign o_legal = (i_addr[30:31] == 2'b00) && (i_addr <= LAST_WORD);

endmodule

// File: rtl/instruction_fetch_unit.sv
// Fetch stage: owns the PC, drives the instruction memory address and tags each
// returned word with its PC and a valid bit; handles stall, redirect and sticky fault.
module instruction_fetch_unit
  import instruction_fetch_unit_pkg::*;
#(
  parameter logic [0:31] RESET_PC  = RESET_PC_DEFAULT,
  parameter int          MEM_BYTES = MEM_BYTES_DEFAULT,
  parameter int          PC_STEP   = PC_STEP_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        redirect_valid,
  input  logic [0:31] redirect_target,
  output logic [0:31] mem_address,
  input  logic [0:31] mem_instruction,
  output logic [0:31] fetch_instr,
  output logic [0:31] fetch_pc,
  output logic        fetch_valid,
  output logic        fetch_fault,
  output logic [0:31] fetch_count
);

  logic [0:31]  r_pc;
  logic [0:31]  r_resp_pc;
  logic         r_resp_valid;
  fetch_state_e r_st;
  logic [0:31]  r_cnt;

  logic [0:31]  w_pc_next;
  logic [0:31]  w_resp_pc_next;
  logic         w_resp_valid_next;
  fetch_state_e w_st_next;
  logic [0:31]  w_cnt_next;

  logic         w_tgt_legal;
  logic         w_pc_legal;
  logic         w_fetch_valid;

  fetch_addr_check #(.MEM_BYTES(MEM_BYTES)) u_tgt_check (
    .i_addr  (redirect_target),
    .o_legal (w_tgt_legal)
  );

  fetch_addr_check #(.MEM_BYTES(MEM_BYTES)) u_pc_check (
    .i_addr  (r_pc),
    .o_legal (w_pc_legal)
  );

  // A redirect squashes the word currently on the memory bus.
  assign w_fetch_valid = r_resp_valid && !redirect_valid && (r_st == RUN);

  always_comb begin
    mem_address = r_pc;
    if (r_st == FAULT)       mem_address = r_resp_pc;
    else if (redirect_valid) mem_address = redirect_target;
    else if (stall)          mem_address = r_resp_pc;
  end

  always_comb begin
    w_pc_next         = r_pc;
    w_resp_pc_next    = r_resp_pc;
    w_resp_valid_next = r_resp_valid;
    w_st_next         = r_st;
    w_cnt_next        = r_cnt;

    if (w_fetch_valid && !stall) w_cnt_next = r_cnt + 32'd1;

    case (r_st)
      RUN: begin
        if (redirect_valid) begin
          if (w_tgt_legal) begin
            w_resp_pc_next    = redirect_target;
            w_resp_valid_next = 1'b1;
            w_pc_next         = redirect_target + 32'(PC_STEP);
          end else begin
            w_st_next         = FAULT;
            w_resp_valid_next = 1'b0;
          end
        end else if (!stall) begin
          // Sequential wrap past memory end is caught here rather than silently.
          if (w_pc_legal) begin
            w_resp_pc_next    = r_pc;
            w_resp_valid_next = 1'b1;
            w_pc_next         = r_pc + 32'(PC_STEP);
          end else begin
            w_st_next         = FAULT;
            w_resp_valid_next = 1'b0;
          end
        end
      end
      FAULT: begin
        w_resp_valid_next = 1'b0;
      end
      default: begin
        w_st_next = FAULT;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_pc         <= RESET_PC;
      r_resp_pc    <= RESET_PC;
      r_resp_valid <= 1'b0;
      r_st         <= RUN;
      r_cnt        <= 32'd0;
    end else begin
      r_pc         <= w_pc_next;
      r_resp_pc    <= w_resp_pc_next;
      r_resp_valid <= w_resp_valid_next;
      r_st         <= w_st_next;
      r_cnt        <= w_cnt_next;
    end
  end

  assign fetch_instr = mem_instruction;
  assign fetch_pc    = r_resp_pc;
  assign fetch_valid = w_fetch_valid;
  assign fetch_fault = (r_st == FAULT);
  assign fetch_count = r_cnt;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Directed bench: fetch unit paired with a behavioural instruction memory
// whose contents are a known function of the word address.
module tb_instruction_fetch_unit;

  logic        clk;
  logic        reset;
  logic        stall;
  logic        redirect_valid;
  logic [0:31] redirect_target;
  logic [0:31] mem_address;
  logic [0:31] mem_instruction;
  logic [0:31] fetch_instr;
  logic [0:31] fetch_pc;
  logic        fetch_valid;
  logic        fetch_fault;
  logic [0:31] fetch_count;

  int total = 0;
  int bad   = 0;

  instruction_fetch_unit dut (
    .clk             (clk),
    .reset           (reset),
    .stall           (stall),
    .redirect_valid  (redirect_valid),
    .redirect_target (redirect_target),
    .mem_address     (mem_address),
    .mem_instruction (mem_instruction),
    .fetch_instr     (fetch_instr),
    .fetch_pc        (fetch_pc),
    .fetch_valid     (fetch_valid),
    .fetch_fault     (fetch_fault),
    .fetch_count     (fetch_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [0:31] word_at(input logic [0:31] a);
    return (a * 32'h0001_0001) ^ 32'hC3C3_0000;
  endfunction

  // Preloaded memory: registered read, one edge of latency.
  always @(posedge clk) mem_instruction <= word_at(mem_address);

  typedef struct {
    logic        rst;
    logic        stl;
    logic        rdv;
    logic [0:31] tgt;
    bit          chk;
    logic        e_valid;
    logic        e_fault;
    logic [0:31] e_pc;
    logic [0:31] e_cnt;
    logic [0:31] e_addr;
  } vec_t;

  vec_t vecs[20];

  function automatic vec_t mk(input logic rst, input logic stl, input logic rdv,
                              input logic [0:31] tgt, input bit chk,
                              input logic e_valid, input logic e_fault,
                              input logic [0:31] e_pc, input logic [0:31] e_cnt,
                              input logic [0:31] e_addr);
    vec_t v;
    v.rst = rst; v.stl = stl; v.rdv = rdv; v.tgt = tgt; v.chk = chk;
    v.e_valid = e_valid; v.e_fault = e_fault; v.e_pc = e_pc;
    v.e_cnt = e_cnt; v.e_addr = e_addr;
    return v;
  endfunction

  task automatic check(input string name, input logic [0:31] act, input logic [0:31] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic rst, input logic stl, input logic rdv, input logic [0:31] tgt);
    reset = rst; stall = stl; redirect_valid = rdv; redirect_target = tgt;
    #3;
  endtask

  task automatic advance();
    @(posedge clk);
    #1;
  endtask

  task automatic check_outs(input string tag, input logic e_valid, input logic e_fault,
                            input logic [0:31] e_pc, input logic [0:31] e_cnt,
                            input logic [0:31] e_addr);
    check({tag, " valid"}, 32'(fetch_valid), 32'(e_valid));
    check({tag, " fault"}, 32'(fetch_fault), 32'(e_fault));
    check({tag, " pc"},    fetch_pc, e_pc);
    check({tag, " count"}, fetch_count, e_cnt);
    check({tag, " addr"},  mem_address, e_addr);
    if (e_valid) check({tag, " instr"}, fetch_instr, word_at(e_pc));
    $display("%s: valid=%0b fault=%0b pc=%h instr=%h count=%0d addr=%h", tag,
             fetch_valid, fetch_fault, fetch_pc, fetch_instr, fetch_count, mem_address);
  endtask

  initial begin
    bit found;

    // rst stl rdv tgt chk  valid fault pc cnt addr
    vecs[0]  = mk(1, 0, 0, 32'h0,  0, 0, 0, 32'h0,  32'd0, 32'h0);
    vecs[1]  = mk(1, 0, 0, 32'h0,  1, 0, 0, 32'h0,  32'd0, 32'h0);
    vecs[2]  = mk(1, 0, 0, 32'h0,  1, 0, 0, 32'h0,  32'd0, 32'h0);
    vecs[3]  = mk(0, 0, 0, 32'h0,  1, 0, 0, 32'h0,  32'd0, 32'h0);
    vecs[4]  = mk(0, 0, 0, 32'h0,  1, 1, 0, 32'h0,  32'd0, 32'h4);
    vecs[5]  = mk(0, 0, 0, 32'h0,  1, 1, 0, 32'h4,  32'd1, 32'h8);
    vecs[6]  = mk(0, 1, 0, 32'h0,  1, 1, 0, 32'h8,  32'd2, 32'h8);
    vecs[7]  = mk(0, 1, 0, 32'h0,  1, 1, 0, 32'h8,  32'd2, 32'h8);
    vecs[8]  = mk(0, 0, 0, 32'h0,  1, 1, 0, 32'h8,  32'd2, 32'hC);
    vecs[9]  = mk(0, 0, 1, 32'h40, 1, 0, 0, 32'hC,  32'd3, 32'h40);
    vecs[10] = mk(0, 0, 0, 32'h0,  1, 1, 0, 32'h40, 32'd3, 32'h44);
    vecs[11] = mk(0, 0, 0, 32'h0,  1, 1, 0, 32'h44, 32'd4, 32'h48);
    vecs[12] = mk(0, 1, 1, 32'h20, 1, 0, 0, 32'h48, 32'd5, 32'h20);
    vecs[13] = mk(0, 0, 0, 32'h0,  1, 1, 0, 32'h20, 32'd5, 32'h24);
    vecs[14] = mk(0, 0, 1, 32'h42, 1, 0, 0, 32'h24, 32'd6, 32'h42);
    vecs[15] = mk(0, 0, 0, 32'h0,  1, 0, 1, 32'h24, 32'd6, 32'h24);
    vecs[16] = mk(0, 1, 1, 32'h40, 1, 0, 1, 32'h24, 32'd6, 32'h24);
    vecs[17] = mk(1, 0, 0, 32'h0,  0, 0, 0, 32'h0,  32'd0, 32'h0);
    vecs[18] = mk(0, 0, 0, 32'h0,  1, 0, 0, 32'h0,  32'd0, 32'h0);
    vecs[19] = mk(0, 0, 0, 32'h0,  1, 1, 0, 32'h0,  32'd0, 32'h4);

    reset = 1'b1; stall = 1'b0; redirect_valid = 1'b0; redirect_target = 32'h0;
    advance();

    for (int i = 0; i < 20; i++) begin
      drive(vecs[i].rst, vecs[i].stl, vecs[i].rdv, vecs[i].tgt);
      if (vecs[i].chk)
        check_outs($sformatf("row%0d", i), vecs[i].e_valid, vecs[i].e_fault,
                   vecs[i].e_pc, vecs[i].e_cnt, vecs[i].e_addr);
      advance();
    end

    // Sequential run up to the last legal word, then the wrap faults.
    found = 1'b0;
    for (int i = 0; i < 700 && !found; i++) begin
      drive(0, 0, 0, 32'h0);
      if (fetch_valid && fetch_pc == 32'h7FC) found = 1'b1;
      else advance();
    end
    check("reach_7fc", 32'(found), 32'd1);
    check_outs("last_word", 1, 0, 32'h7FC, 32'd511, 32'h800);
    advance();
    drive(0, 0, 0, 32'h0);
    check_outs("wrap_fault", 0, 1, 32'h7FC, 32'd512, 32'h7FC);
    advance();

    // Reset asserted while stalled restarts cleanly from RESET_PC.
    drive(1, 0, 0, 32'h0); advance();
    drive(0, 0, 0, 32'h0);
    check_outs("rs_a", 0, 0, 32'h0, 32'd0, 32'h0);
    advance();
    drive(0, 0, 0, 32'h0);
    check_outs("rs_b", 1, 0, 32'h0, 32'd0, 32'h4);
    advance();
    drive(0, 1, 0, 32'h0);
    check_outs("rs_c", 1, 0, 32'h4, 32'd1, 32'h4);
    advance();
    drive(1, 1, 0, 32'h0); advance();
    drive(0, 0, 0, 32'h0);
    check_outs("rs_e", 0, 0, 32'h0, 32'd0, 32'h0);
    advance();
    drive(0, 0, 0, 32'h0);
    check_outs("rs_f", 1, 0, 32'h0, 32'd0, 32'h4);
    advance();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
